// File: rtl/spc700_dbg.sv
// SPC700 debug unit: address/exec breakpoints with pass counters, single-step and a sticky
// break request cleared by a rising run bit.
module spc700_dbg #(
   parameter int unsigned NUM_BRK = 4,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EN,
   input  logic        LAST_CYCLE,
   input  logic [15:0] NEXT_PC,
   input  logic [15:0] A_OUT,
   input  logic        WE_N,
   input  logic [7:0]  DBG_REG,
   input  logic [7:0]  DBG_DAT_IN,
   input  logic        DBG_DAT_WR,
   output logic [7:0]  DBG_DAT_OUT,
   output logic        BRK_OUT,
   output logic [3:0]  BRK_ID
);

   logic             wr_q;
   logic             rst_q;
   logic             run_q;
   logic [7:0]       gctrl_q;
   logic [15:0]      addr_q [NUM_BRK];
   logic [7:0]       ctrl_q [NUM_BRK];
   logic [CNT_W-1:0] pass_q [NUM_BRK];
   logic [CNT_W-1:0] hc_q   [NUM_BRK];
   logic [CNT_W-1:0] hc_d   [NUM_BRK];
   logic [CNT_W:0]   hc_inc [NUM_BRK];
   logic             brk_q, brk_d;
   logic [3:0]       brk_id_q, brk_id_d;

   logic               wr_edge, run_edge, step_hit;
   logic               sel_chan;
   logic [2:0]         sel_ch;
   logic [1:0]         sel_off;
   logic [NUM_BRK-1:0] chan_wr, mode_hit, match, fire;
   logic [3:0]         fire_low;
   logic [15:0]        sel_addr;
   logic [7:0]         sel_ctrl;
   logic [7:0]         sel_hc;

   // The cycle right after reset is masked so a strobe held across reset release is not an edge.
   assign wr_edge  = DBG_DAT_WR & ~wr_q & ~rst_q;
   assign run_edge = gctrl_q[7] & ~run_q;
   assign step_hit = gctrl_q[0] & EN & LAST_CYCLE;
   assign sel_ch   = DBG_REG[4:2];
   assign sel_off  = DBG_REG[1:0];
   assign sel_chan = (DBG_REG[7:5] == 3'b100) && (int'(sel_ch) < int'(NUM_BRK));

   always_comb begin
      for (int i = 0; i < NUM_BRK; i++) begin
         chan_wr[i] = wr_edge && sel_chan && (int'(sel_ch) == i);
         unique case (ctrl_q[i][2:1])
            2'b00:   mode_hit[i] = LAST_CYCLE && (NEXT_PC == addr_q[i]);
            2'b01:   mode_hit[i] = WE_N && (A_OUT == addr_q[i]);
            2'b10:   mode_hit[i] = !WE_N && (A_OUT == addr_q[i]);
            default: mode_hit[i] = (A_OUT == addr_q[i]);
         endcase
         // A register write to the channel in the same cycle discards its match.
         match[i]  = EN && ctrl_q[i][0] && mode_hit[i] && !chan_wr[i];
         hc_inc[i] = {1'b0, hc_q[i]} + 1'b1;
         fire[i]   = match[i] && (hc_inc[i] >= {1'b0, pass_q[i]});
         if (chan_wr[i] || fire[i]) begin
            hc_d[i] = '0;
         end else if (match[i] && !(&hc_q[i])) begin
            hc_d[i] = hc_q[i] + 1'b1;
         end else begin
            hc_d[i] = hc_q[i];
         end
      end
   end

   always_comb begin
      fire_low = 4'hF;
      for (int i = int'(NUM_BRK) - 1; i >= 0; i--) begin
         if (fire[i]) fire_low = 4'(i);
      end
      brk_d    = brk_q;
      brk_id_d = brk_id_q;
      if ((|fire) || step_hit) begin
         brk_d    = 1'b1;
         brk_id_d = fire_low;
      end else if (run_edge) begin
         brk_d = 1'b0;
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_ctrl = '0;
      sel_hc   = '0;
      for (int i = 0; i < NUM_BRK; i++) begin
         if (int'(sel_ch) == i) begin
            sel_addr           = addr_q[i];
            sel_ctrl           = ctrl_q[i];
            sel_hc[CNT_W-1:0]  = hc_q[i];
         end
      end
      DBG_DAT_OUT = 8'h00;
      if (sel_chan) begin
         unique case (sel_off)
            2'd0:    DBG_DAT_OUT = sel_addr[7:0];
            2'd1:    DBG_DAT_OUT = sel_addr[15:8];
            2'd2:    DBG_DAT_OUT = sel_ctrl;
            default: DBG_DAT_OUT = sel_hc;
         endcase
      end else if (DBG_REG == 8'hC0) begin
         DBG_DAT_OUT = gctrl_q;
      end else if (DBG_REG == 8'hC1) begin
         DBG_DAT_OUT = {brk_q, 3'b000, brk_id_q};
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_q     <= 1'b0;
         rst_q    <= 1'b1;
         run_q    <= 1'b0;
         gctrl_q  <= 8'h00;
         brk_q    <= 1'b0;
         brk_id_q <= 4'h0;
         for (int i = 0; i < NUM_BRK; i++) begin
            addr_q[i] <= 16'hFFFF;
            ctrl_q[i] <= 8'h00;
            pass_q[i] <= '0;
            hc_q[i]   <= '0;
         end
      end else begin
         wr_q     <= DBG_DAT_WR;
         rst_q    <= 1'b0;
         run_q    <= gctrl_q[7];
         brk_q    <= brk_d;
         brk_id_q <= brk_id_d;
         if (wr_edge && (DBG_REG == 8'hC0)) gctrl_q <= DBG_DAT_IN;
         for (int i = 0; i < NUM_BRK; i++) begin
            hc_q[i] <= hc_d[i];
            if (chan_wr[i]) begin
               unique case (sel_off)
                  2'd0:    addr_q[i][7:0]  <= DBG_DAT_IN;
                  2'd1:    addr_q[i][15:8] <= DBG_DAT_IN;
                  2'd2:    ctrl_q[i]       <= DBG_DAT_IN;
                  default: pass_q[i]       <= DBG_DAT_IN[CNT_W-1:0];
               endcase
            end
         end
      end
   end

   assign BRK_OUT = brk_q;
   assign BRK_ID  = brk_id_q;

endmodule

// File: tb/tb_spc700_dbg.sv
// Scoreboard bench for spc700_dbg: dut 0 uses default parameters, dut 1 uses NUM_BRK=2, CNT_W=2.
module tb_spc700_dbg;

   logic        CLK;
   logic        RST;
   logic        en [2];
   logic        last [2];
   logic [15:0] next_pc [2];
   logic [15:0] a_out [2];
   logic        we_n [2];
   logic [7:0]  dbg_reg [2];
   logic [7:0]  dbg_din [2];
   logic        dbg_wr_s [2];
   logic [7:0]  a_dat, b_dat;
   logic        a_brk, b_brk;
   logic [3:0]  a_id, b_id;

   typedef struct {
      int         d;
      int         kind;
      logic [7:0] exp;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   spc700_dbg u_dut_a (
      .CLK(CLK), .RST(RST), .EN(en[0]), .LAST_CYCLE(last[0]), .NEXT_PC(next_pc[0]),
      .A_OUT(a_out[0]), .WE_N(we_n[0]), .DBG_REG(dbg_reg[0]), .DBG_DAT_IN(dbg_din[0]),
      .DBG_DAT_WR(dbg_wr_s[0]), .DBG_DAT_OUT(a_dat), .BRK_OUT(a_brk), .BRK_ID(a_id)
   );

   spc700_dbg #(.NUM_BRK(2), .CNT_W(2)) u_dut_b (
      .CLK(CLK), .RST(RST), .EN(en[1]), .LAST_CYCLE(last[1]), .NEXT_PC(next_pc[1]),
      .A_OUT(a_out[1]), .WE_N(we_n[1]), .DBG_REG(dbg_reg[1]), .DBG_DAT_IN(dbg_din[1]),
      .DBG_DAT_WR(dbg_wr_s[1]), .DBG_DAT_OUT(b_dat), .BRK_OUT(b_brk), .BRK_ID(b_id)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Monitor: drains every expectation queued during the cycle at the falling edge.
   always @(negedge CLK) begin : monitor
      exp_t       e;
      logic [7:0] act;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         case (e.kind)
            0:       act = (e.d == 1) ? b_dat : a_dat;
            1:       act = {7'd0, (e.d == 1) ? b_brk : a_brk};
            default: act = {4'd0, (e.d == 1) ? b_id : a_id};
         endcase
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s (dut%0d kind%0d): got %02h expected %02h",
                     e.name, e.d, e.kind, act, e.exp);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic push(input int d, input int kind, input logic [7:0] v, input string name);
      exp_t e;
      e.d = d; e.kind = kind; e.exp = v; e.name = name;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int d);
      en[d] = 1'b0; last[d] = 1'b0; next_pc[d] = 16'h0000; a_out[d] = 16'h0000; we_n[d] = 1'b1;
   endtask

   task automatic dbg_wr(input int d, input logic [7:0] r, input logic [7:0] v);
      dbg_reg[d] = r; dbg_din[d] = v; dbg_wr_s[d] = 1'b1;
      tick();
      dbg_wr_s[d] = 1'b0;
      tick();
   endtask

   task automatic rd(input int d, input logic [7:0] r, input logic [7:0] v, input string name);
      dbg_reg[d] = r;
      push(d, 0, v, name);
      tick();
   endtask

   task automatic brk(input int d, input logic o, input logic [7:0] id, input string name);
      push(d, 1, {7'd0, o}, name);
      push(d, 2, id, name);
   endtask

   task automatic cpu(input int d, input logic e, input logic l, input logic [15:0] pc,
                      input logic [15:0] a, input logic w);
      en[d] = e; last[d] = l; next_pc[d] = pc; a_out[d] = a; we_n[d] = w;
      tick();
      idle(d);
   endtask

   task automatic clear_brk(input int d);
      dbg_wr(d, 8'hC0, 8'h00);
      dbg_wr(d, 8'hC0, 8'h80);
   endtask

   initial begin
      RST = 1'b1;
      for (int d = 0; d < 2; d++) begin
         idle(d);
         dbg_reg[d] = 8'h00; dbg_din[d] = 8'h00; dbg_wr_s[d] = 1'b0;
      end
      // Strobe held high across reset release must not write CTRL0.
      dbg_reg[0] = 8'h82; dbg_din[0] = 8'h55; dbg_wr_s[0] = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      tick(); tick();
      dbg_wr_s[0] = 1'b0;
      tick();

      brk(0, 1'b0, 8'h00, "rst_brk_a");
      rd(0, 8'h82, 8'h00, "wr_held_over_rst");
      rd(0, 8'h80, 8'hFF, "rst_addr_lo");
      rd(0, 8'h81, 8'hFF, "rst_addr_hi");
      rd(0, 8'h83, 8'h00, "rst_hc");
      rd(0, 8'hC0, 8'h00, "rst_gctrl");
      rd(0, 8'hC1, 8'h00, "rst_status");
      brk(1, 1'b0, 8'h00, "rst_brk_b");
      rd(1, 8'h81, 8'hFF, "rst_addr_b");

      // Exec breakpoint on ch0.
      dbg_wr(0, 8'h80, 8'h00);
      dbg_wr(0, 8'h81, 8'h04);
      dbg_wr(0, 8'h83, 8'h00);
      dbg_wr(0, 8'h82, 8'h01);
      cpu(0, 1'b1, 1'b1, 16'h0401, 16'h0000, 1'b1);
      brk(0, 1'b0, 8'h00, "exec_miss");
      cpu(0, 1'b1, 1'b1, 16'h0400, 16'h0000, 1'b1);
      brk(0, 1'b1, 8'h00, "exec_hit");
      rd(0, 8'hC1, 8'h80, "exec_status");

      // Run edge clears; rewriting the same value does not.
      dbg_wr(0, 8'hC0, 8'h80);
      brk(0, 1'b0, 8'h00, "run_clear");
      cpu(0, 1'b1, 1'b1, 16'h0400, 16'h0000, 1'b1);
      brk(0, 1'b1, 8'h00, "rebreak");
      dbg_wr(0, 8'hC0, 8'h80);
      brk(0, 1'b1, 8'h00, "run_hold_no_clear");
      dbg_wr(0, 8'hC0, 8'h00);
      dbg_reg[0] = 8'hC0; dbg_din[0] = 8'h80; dbg_wr_s[0] = 1'b1;
      tick();
      dbg_wr_s[0] = 1'b0;
      cpu(0, 1'b1, 1'b1, 16'h0400, 16'h0000, 1'b1);
      brk(0, 1'b1, 8'h00, "brk_beats_run");
      tick();
      dbg_wr(0, 8'h82, 8'h00);

      // Pass counter on ch1 write mode.
      clear_brk(0);
      brk(0, 1'b0, 8'h00, "clear_before_pass");
      dbg_wr(0, 8'h84, 8'hF4);
      dbg_wr(0, 8'h85, 8'h00);
      dbg_wr(0, 8'h86, 8'hAD);
      dbg_wr(0, 8'h87, 8'h03);
      rd(0, 8'h86, 8'hAD, "ctrl_readback");
      cpu(0, 1'b1, 1'b0, 16'h0000, 16'h00F4, 1'b1);
      rd(0, 8'h87, 8'h00, "read_no_count");
      cpu(0, 1'b1, 1'b0, 16'h0000, 16'h00F4, 1'b0);
      brk(0, 1'b0, 8'h00, "pass_w1");
      rd(0, 8'h87, 8'h01, "pass_hc1");
      cpu(0, 1'b1, 1'b0, 16'h0000, 16'h00F4, 1'b0);
      brk(0, 1'b0, 8'h00, "pass_w2");
      rd(0, 8'h87, 8'h02, "pass_hc2");
      cpu(0, 1'b1, 1'b0, 16'h0000, 16'h00F4, 1'b0);
      brk(0, 1'b1, 8'h01, "pass_w3");
      rd(0, 8'h87, 8'h00, "pass_hc_cleared");
      rd(0, 8'h85, 8'h00, "pass_addr_hi");

      // Step plus two simultaneous exec channels.
      clear_brk(0);
      dbg_wr(0, 8'h88, 8'h34);
      dbg_wr(0, 8'h89, 8'h12);
      dbg_wr(0, 8'h8A, 8'h01);
      dbg_wr(0, 8'h8B, 8'h02);
      dbg_wr(0, 8'h8C, 8'h34);
      dbg_wr(0, 8'h8D, 8'h12);
      dbg_wr(0, 8'h8E, 8'h01);
      dbg_wr(0, 8'h8F, 8'h02);
      dbg_wr(0, 8'hC0, 8'h81);
      rd(0, 8'hC0, 8'h81, "gctrl_rb");
      cpu(0, 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b1);
      brk(0, 1'b1, 8'h0F, "step_only");
      rd(0, 8'h8B, 8'h01, "prio_hc2_1");
      rd(0, 8'h8F, 8'h01, "prio_hc3_1");
      cpu(0, 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b1);
      brk(0, 1'b1, 8'h02, "prio_lowest");
      rd(0, 8'h8B, 8'h00, "prio_hc2_clr");
      rd(0, 8'h8F, 8'h00, "prio_hc3_clr");
      rd(0, 8'hC1, 8'h82, "prio_status");
      dbg_wr(0, 8'hC0, 8'h80);

      // EN=0 blocks matching; unmapped and read-only registers.
      cpu(0, 1'b0, 1'b1, 16'h1234, 16'h00F4, 1'b0);
      brk(0, 1'b1, 8'h02, "en0_no_brk");
      rd(0, 8'h87, 8'h00, "en0_no_count");
      rd(0, 8'h8B, 8'h00, "en0_no_count_exec");
      dbg_wr(0, 8'hA0, 8'h5A);
      rd(0, 8'hA0, 8'h00, "unmapped");
      dbg_wr(0, 8'hC1, 8'h00);
      rd(0, 8'hC1, 8'h82, "status_ro");

      // NUM_BRK=2 / CNT_W=2 instance.
      dbg_wr(1, 8'h88, 8'h12);
      rd(1, 8'h88, 8'h00, "chan_oob");
      rd(1, 8'h8B, 8'h00, "chan_oob_hc");
      dbg_wr(1, 8'h80, 8'h10);
      dbg_wr(1, 8'h81, 8'h00);
      dbg_wr(1, 8'h82, 8'h01);
      dbg_wr(1, 8'h83, 8'hFF);
      rd(1, 8'h83, 8'h00, "trunc_hc0");
      cpu(1, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b1);
      brk(1, 1'b0, 8'h00, "trunc_m1");
      rd(1, 8'h83, 8'h01, "trunc_hc1");
      cpu(1, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b1);
      brk(1, 1'b0, 8'h00, "trunc_m2");
      rd(1, 8'h83, 8'h02, "trunc_hc2");
      cpu(1, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b1);
      brk(1, 1'b1, 8'h00, "trunc_fire");
      rd(1, 8'h83, 8'h00, "trunc_hc_clr");
      clear_brk(1);
      cpu(1, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b1);
      cpu(1, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b1);
      rd(1, 8'h83, 8'h02, "pre_discard_hc");
      dbg_reg[1] = 8'h82; dbg_din[1] = 8'h01; dbg_wr_s[1] = 1'b1;
      cpu(1, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b1);
      dbg_wr_s[1] = 1'b0;
      brk(1, 1'b0, 8'h00, "wr_discards_match");
      rd(1, 8'h83, 8'h00, "wr_clears_hc");

      // Reset mid-count while break is asserted.
      cpu(0, 1'b1, 1'b0, 16'h0000, 16'h00F4, 1'b0);
      rd(0, 8'h87, 8'h01, "mid_hc");
      RST = 1'b1;
      tick();
      RST = 1'b0;
      brk(0, 1'b0, 8'h00, "rst_mid");
      rd(0, 8'h87, 8'h00, "rst_mid_hc");
      rd(0, 8'h84, 8'hFF, "rst_mid_addr");
      rd(0, 8'h86, 8'h00, "rst_mid_ctrl");
      rd(0, 8'hC0, 8'h00, "rst_mid_gctrl");
      tick();

      checks++;
      if ((a_brk | b_brk) !== 1'b0) begin
         errors++;
         $display("FAIL final_brk: got a=%0b b=%0b expected 0", a_brk, b_brk);
      end
      if (checks < 12) begin
         errors++;
         $display("FAIL too few checks executed: %0d", checks);
      end
      if (errors != 0) begin
         $display("FAIL: %0d errors", errors);
      end else begin
         $display("PASS");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
